fram_spi_target: RTL
====================

// Module: fram_spi_target
// PURPOSE
//  Synthesizable SPI mode-0 responder that emulates a byte-addressed SPI FRAM.
//  It is the far end of the fram_spi / fram_ram master path.
//  Use: on-chip or FPGA stand-in for the external FRAM, and loopback target in system benches.
//  Serves READ, WRITE, WREN, WRDI and RDSR from an internal byte array; address auto-increments.
// PARAMETERS
//  ADDR_WIDTH  16   address bits sent on the wire; multiple of 8 (ADDR_WIDTH/8 address bytes)
//  MEM_DEPTH   256  bytes of backing store; power of 2; wire address used modulo MEM_DEPTH
// PORTS
//  clk        in   1  system clock; must be >= 4x SCK frequency
//  rst_n      in   1  asynchronous, active-low reset
//  spi_sck    in   1  SPI clock from master, idles low
//  spi_cs_n   in   1  chip select, active low
//  spi_mosi   in   1  master-out data, MSB first
//  spi_miso   out  1  target-out data, MSB first
//  wel        out  1  write-enable latch status
//  busy       out  1  high while synchronized cs_n is low
//  cmd_err    out  1  one-clk pulse when an unknown opcode completes
//  dbg_addr   in   $clog2(MEM_DEPTH)  backdoor read address (bench/debug)
//  dbg_rdata  out  8  combinational backdoor read of mem[dbg_addr]
// BEHAVIOUR
//  - Reset: spi_miso=0, wel=0, busy=0, cmd_err=0, FSM=IDLE, shift/bit counters=0.
//  - Memory array is not reset.
//  - sck, cs_n and mosi pass through 2-FF synchronizers; sck rise/fall detected in the clk domain.
//    Decoded events lag the pins by 3 clk.
//  - Bits are sampled on SCK rise; MISO updates on SCK fall; bit counter 0..7 per byte.
//    spi_miso=0 whenever cs_n is high or no read/status data is pending.
//  - FSM states:
//     IDLE   : cs_n falls -> CMD, counters cleared.
//     CMD    : 8th bit completes the opcode.
//              06 -> set WEL, then IGNORE.  04 -> clear WEL, then IGNORE.
//              05 -> STATUS.  03 -> ADDR (read).  02 -> ADDR (write).
//              other -> pulse cmd_err, then IGNORE.
//     ADDR   : collects ADDR_WIDTH bits MSB-first, then moves to READ or WRITE.
//              On the last address bit, mem[addr mod MEM_DEPTH] loads into the TX shift register.
//              bit7 is driven on the following SCK fall.
//     READ   : each completed byte increments addr and preloads the next byte.
//              Frame continues until cs_n rises.
//     WRITE  : each completed 8-bit byte is written to mem[addr] only if wel=1, then addr+1.
//              With wel=0 the data is discarded.
//     STATUS : returns {6'b0, wel, 1'b0} repeatedly until cs_n rises.
//     IGNORE : shifts and ignores bits until cs_n rises.
//  - cs_n rise, any state -> IDLE next clk; a partial byte is discarded and never written.
//  - Clearing WEL at cs_n rise happens only if the frame was WRITE with >=1 committed byte.
//  - Address wrap: addr increments modulo MEM_DEPTH; MEM_DEPTH-1 is followed by 0.
//  - Upper address bits beyond $clog2(MEM_DEPTH) are ignored.
//  - Same-clk sck edge and cs_n rise: cs_n rise wins; the edge is ignored.
//  - cs_n low with no sck edges: state holds indefinitely.
//  - Async reset mid-frame: immediate return to reset values.
//    The frame in progress is dropped; already committed bytes persist.
//  - dbg_rdata is combinational and may be read at any time.
//    A same-clk write to that address is visible from the next clk.
// STRUCTURE
//  - Shared package fram_spi_pkg: opcode constants (OP_READ=8'h03, OP_WRITE=8'h02,
//    OP_WREN=8'h06, OP_WRDI=8'h04, OP_RDSR=8'h05) and the FSM state encoding.
//    fram_spi (master) imports the same opcodes.
//  - One sub-module: spi_target_sync, the 2-FF synchronizers plus sck rise/fall and
//    cs_n fall/rise strobes.
//  - Top level holds the FSM, RX/TX shift registers, address counter, WEL and the byte array.
// TESTING
//  1. WREN; WRITE addr 0x0010 data A5 5A; cs_n high ->
//     dbg 0x10=A5, 0x11=5A; wel 1 after WREN, 0 after the write frame.
//  2. WRDI (or reset), then WRITE 0x0020 data 77 -> mem[0x20] unchanged; wel stays 0; no cmd_err.
//  3. READ 0x0010, clock 16 data bits -> MISO yields A5 then 5A; MISO 0 after cs_n rises.
//  4. WREN; WRITE 0x00FF data 11 22 (MEM_DEPTH=256) -> mem[FF]=11, mem[00]=22;
//     READ 0x00FF 2 bytes returns 11 22.
//  5. WREN; RDSR -> 0x02.
//     Opcode 0x9F -> cmd_err one pulse, MISO 0.
//     WRITE aborted after 5 data bits -> target byte unchanged.
//  6. fram_ram connected to this target: sw 0xDEADBEEF to 0x40, lw returns 0xDEADBEEF.
//     lb 0x43 with sign_ext returns 0xFFFFFFDE.
//     rst_n pulsed mid-lw -> wel=0, MISO=0, and the next access completes correctly.

Source files
------------

// File: rtl/fram_spi_pkg.sv
// fram_spi_pkg: opcodes and target FSM encoding shared by the FRAM SPI master and target.
package fram_spi_pkg;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_READ,
    ST_WRITE,
    ST_STATUS,
    ST_IGNORE
  } state_e;
endpackage

// File: rtl/spi_target_sync.sv
// spi_target_sync: 2-FF synchronizers for the SPI pins plus registered sck/cs_n edge strobes.
module spi_target_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sck_i,
  input  logic cs_n_i,
  input  logic mosi_i,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic cs_fall_o,
  output logic cs_rise_o,
  output logic cs_n_o,
  output logic mosi_o
);
  logic [2:0] sck_q, cs_q, mosi_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sck_q      <= '0;
      cs_q       <= '1;
      mosi_q     <= '0;
      sck_rise_o <= 1'b0;
      sck_fall_o <= 1'b0;
      cs_fall_o  <= 1'b0;
      cs_rise_o  <= 1'b0;
    end else begin
      sck_q      <= {sck_q[1:0], sck_i};
      cs_q       <= {cs_q[1:0], cs_n_i};
      mosi_q     <= {mosi_q[1:0], mosi_i};
      sck_rise_o <= sck_q[1] & ~sck_q[2];
      sck_fall_o <= ~sck_q[1] & sck_q[2];
      cs_fall_o  <= ~cs_q[1] & cs_q[2];
      cs_rise_o  <= cs_q[1] & ~cs_q[2];
    end
  // mosi takes one extra stage so it lines up with the registered sck strobe
  assign mosi_o = mosi_q[2];
  assign cs_n_o = cs_q[1];
endmodule

// File: rtl/fram_spi_target.sv
// fram_spi_target: SPI mode-0 responder emulating a byte-addressed FRAM (READ/WRITE/WREN/WRDI/RDSR).
module fram_spi_target
  import fram_spi_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         spi_sck,
  input  logic                         spi_cs_n,
  input  logic                         spi_mosi,
  output logic                         spi_miso,
  output logic                         wel,
  output logic                         busy,
  output logic                         cmd_err,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [7:0]                   dbg_rdata
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(ADDR_WIDTH);
  logic sck_rise, sck_fall, cs_fall, cs_rise, cs_n_s, mosi_s;
  state_e state_q;
  logic [2:0] bit_q;
  logic [CW-1:0] acnt_q;
  logic [7:0] rx_q, tx_q;
  logic [AW-1:0] addr_q;
  logic rd_q, wel_q, miso_q, err_q, done_q;
  logic [7:0] mem [MEM_DEPTH];
  logic [7:0] rx_d;
  logic [AW-1:0] addr_d, addr_inc;
  logic wr_en;
  spi_target_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .sck_i     (spi_sck),
    .cs_n_i    (spi_cs_n),
    .mosi_i    (spi_mosi),
    .sck_rise_o(sck_rise),
    .sck_fall_o(sck_fall),
    .cs_fall_o (cs_fall),
    .cs_rise_o (cs_rise),
    .cs_n_o    (cs_n_s),
    .mosi_o    (mosi_s)
  );
  assign rx_d     = {rx_q[6:0], mosi_s};
  assign addr_d   = {addr_q[AW-2:0], mosi_s};
  assign addr_inc = addr_q + 1'b1;
  assign wr_en    = sck_rise && !cs_rise && state_q == ST_WRITE && bit_q == 3'd7 && wel_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      acnt_q  <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wel_q   <= 1'b0;
      miso_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (cs_rise) begin
        state_q <= ST_IDLE;
        miso_q  <= 1'b0;
        if (state_q == ST_WRITE && done_q) wel_q <= 1'b0;
      end else if (state_q == ST_IDLE) begin
        if (cs_fall) begin
          state_q <= ST_CMD;
          bit_q   <= '0;
          acnt_q  <= '0;
          rx_q    <= '0;
          tx_q    <= '0;
          done_q  <= 1'b0;
        end
      end else if (sck_rise) begin
        bit_q <= bit_q + 3'd1;
        rx_q  <= rx_d;
        case (state_q)
          ST_CMD: if (bit_q == 3'd7) begin
            state_q <= (rx_d == OP_READ || rx_d == OP_WRITE) ? ST_ADDR :
                       rx_d == OP_RDSR ? ST_STATUS : ST_IGNORE;
            rd_q    <= rx_d == OP_READ;
            tx_q    <= {6'b0, wel_q, 1'b0};
            wel_q   <= rx_d == OP_WREN ? 1'b1 : rx_d == OP_WRDI ? 1'b0 : wel_q;
            err_q   <= !(rx_d inside {OP_READ, OP_WRITE, OP_WREN, OP_WRDI, OP_RDSR});
          end
          ST_ADDR: begin
            addr_q <= addr_d;
            acnt_q <= acnt_q + 1'b1;
            if (acnt_q == CW'(ADDR_WIDTH - 1)) begin
              state_q <= rd_q ? ST_READ : ST_WRITE;
              tx_q    <= mem[addr_d];
            end
          end
          ST_READ: if (bit_q == 3'd7) begin
            addr_q <= addr_inc;
            tx_q   <= mem[addr_inc];
          end
          ST_WRITE: if (bit_q == 3'd7) begin
            addr_q <= addr_inc;
            done_q <= done_q | wel_q;
          end
          ST_STATUS: if (bit_q == 3'd7) tx_q <= {6'b0, wel_q, 1'b0};
          default: ;
        endcase
      end else if (sck_fall) begin
        miso_q <= (state_q == ST_READ || state_q == ST_STATUS) && tx_q[7];
        tx_q   <= {tx_q[6:0], 1'b0};
      end
    end
  always_ff @(posedge clk)
    if (wr_en) mem[addr_q] <= rx_d;
  // gating with the raw pin keeps MISO quiet the moment the master deselects
  assign spi_miso  = miso_q & ~spi_cs_n;
  assign wel       = wel_q;
  assign busy      = ~cs_n_s;
  assign cmd_err   = err_q;
  assign dbg_rdata = mem[dbg_addr];
endmodule
